// File: rtl/rlc_game_system_led_fader.sv
// Eight-channel LED fader: each LED ramps its brightness toward an on/off target,
// drives the board through an 8-bit PWM, and can be gated by a slow blink phase.
module rlc_game_system_led_fader #(
    parameter int TICK_DIV  = 256,
    parameter int BLINK_DIV = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pattern_in,
    input  logic       blink_en,
    output logic [7:0] led_out,
    output logic       busy,
    output logic       update_pulse
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [7:0]    r_target;
    logic          r_update_pulse;
    logic [PW-1:0] r_presc;
    logic          w_tick;
    logic [7:0]    r_pwm_cnt;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_phase;
    logic [7:0]    r_led_out;
    logic [7:0]    w_lit;
    logic [7:0]    w_off_target;

    // Target follows the PIO every cycle; a difference seen this cycle pulses next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_target       <= 8'h00;
            r_update_pulse <= 1'b0;
        end else begin
            r_target       <= pattern_in;
            r_update_pulse <= (pattern_in != r_target);
        end
    end

    assign w_tick = (r_presc == PRESC_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pwm_cnt <= 8'h00;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end
    end

    // Phase rests high while blinking is disabled so LEDs show solid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (!blink_en) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (w_tick) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
            end
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_led
        logic [7:0] r_bright;

        // Step one count per tick toward the old target; saturate at the rails.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_bright <= 8'h00;
            end else if (w_tick) begin
                if (r_target[gi] && (r_bright != 8'hFF)) begin
                    r_bright <= r_bright + 8'd1;
                end else if (!r_target[gi] && (r_bright != 8'h00)) begin
                    r_bright <= r_bright - 8'd1;
                end
            end
        end

        assign w_lit[gi]        = (r_bright == 8'hFF) || (r_bright > r_pwm_cnt);
        assign w_off_target[gi] = (r_bright != {8{r_target[gi]}});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_led_out <= 8'h00;
        end else begin
            r_led_out <= w_lit & {8{r_blink_phase}};
        end
    end

    assign led_out      = r_led_out;
    assign update_pulse = r_update_pulse;
    assign busy         = |w_off_target;

endmodule

// File: tb/tb_rlc_game_system_led_fader.sv
// Scoreboard bench for the LED fader: a cycle-level reference model predicts
// led_out/busy/update_pulse for every clock and a monitor compares them.
module tb_rlc_game_system_led_fader;

    localparam int TICK_DIV  = 4;
    localparam int BLINK_DIV = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] pattern_in = 8'hFF;
    logic       blink_en = 1'b0;
    logic [7:0] led_out;
    logic       busy;
    logic       update_pulse;

    always #5 clk = ~clk;

    rlc_game_system_led_fader #(
        .TICK_DIV (TICK_DIV),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pattern_in  (pattern_in),
        .blink_en    (blink_en),
        .led_out     (led_out),
        .busy        (busy),
        .update_pulse(update_pulse)
    );

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

    // Reference state: brightness levels, elapsed clocks since reset, blink bookkeeping.
    int         m_bright[8];
    logic [7:0] m_target;
    int         m_cyc;
    int         m_bcnt;
    bit         m_phase;

    function automatic void check(string name, logic [7:0] act, logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_bright[i] = 0;
        m_target = 8'h00;
        m_cyc    = 0;
        m_bcnt   = 0;
        m_phase  = 1'b1;
    endfunction

    // Predict the outputs right after the coming rising edge from current inputs.
    function automatic void model_edge();
        int         pwm;
        bit         tick;
        logic [7:0] led;
        logic       pulse;
        logic       bsy;
        if (reset) begin
            model_reset();
            exp_q.push_back(10'b0);
            return;
        end
        pwm  = m_cyc % 256;
        tick = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
        for (int i = 0; i < 8; i++)
            led[i] = ((m_bright[i] == 255) || (m_bright[i] > pwm)) && m_phase;
        pulse = (pattern_in != m_target);
        if (tick) begin
            for (int i = 0; i < 8; i++) begin
                if (m_target[i] && m_bright[i] < 255) m_bright[i]++;
                else if (!m_target[i] && m_bright[i] > 0) m_bright[i]--;
            end
        end
        if (!blink_en) begin
            m_bcnt  = 0;
            m_phase = 1'b1;
        end else if (tick) begin
            m_bcnt++;
            if (m_bcnt == BLINK_DIV) begin
                m_bcnt  = 0;
                m_phase = !m_phase;
            end
        end
        m_target = pattern_in;
        m_cyc++;
        bsy = 1'b0;
        for (int i = 0; i < 8; i++)
            if (m_bright[i] != (m_target[i] ? 255 : 0)) bsy = 1'b1;
        exp_q.push_back({pulse, bsy, led});
    endfunction

    always @(posedge clk) begin
        logic [9:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("led_out", led_out, e[7:0]);
            check("busy", {7'b0, busy}, {7'b0, e[8]});
            check("update_pulse", {7'b0, update_pulse}, {7'b0, e[9]});
        end
    end

    task automatic run(input logic [7:0] pat, input logic ben, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            pattern_in = pat;
            blink_en   = ben;
            model_edge();
        end
    endtask

    task automatic assert_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_led_out", led_out, 8'h00);
        check("rst_busy", {7'b0, busy}, 8'h00);
        check("rst_update_pulse", {7'b0, update_pulse}, 8'h00);
        model_edge();
    endtask

    task automatic release_reset(input logic [7:0] pat);
        @(negedge clk);
        reset      = 1'b0;
        pattern_in = pat;
        blink_en   = 1'b0;
        model_edge();
    endtask

    initial begin
        model_reset();
        // Reset held with all LEDs requested on.
        run(8'hFF, 1'b0, 3);
        check("init_led_out", led_out, 8'h00);
        check("init_busy", {7'b0, busy}, 8'h00);
        check("init_update_pulse", {7'b0, update_pulse}, 8'h00);
        release_reset(8'h00);
        run(8'h00, 1'b0, 2);

        // Fade-in of LED0 to saturation.
        run(8'h01, 1'b0, 1100);
        check("fadein_led_out", led_out, 8'h01);
        check("fadein_busy", {7'b0, busy}, 8'h00);

        // Reversal at brightness 100.
        run(8'h00, 1'b0, 1100);
        run(8'h01, 1'b0, 400);
        run(8'h00, 1'b0, 450);
        check("reverse_led_out", led_out, 8'h00);

        // Blink at full brightness, then back to solid.
        run(8'h01, 1'b0, 1100);
        run(8'h01, 1'b1, 64);
        run(8'h01, 1'b0, 16);

        // Reset in the middle of a fade at brightness 50.
        run(8'h00, 1'b0, 1100);
        run(8'h01, 1'b0, 200);
        assert_reset();
        run(8'h01, 1'b0, 2);
        release_reset(8'h01);
        run(8'h01, 1'b0, 300);

        // Randomized patterns, blink windows, glitch bursts and resets.
        for (int ph = 0; ph < 40; ph++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                assert_reset();
                run(8'($urandom), 1'b0, $urandom_range(1, 3));
                release_reset(8'($urandom));
            end else if (kind < 3) begin
                for (int k = 0; k < 30; k++)
                    run(8'($urandom), ($urandom_range(0, 1) == 0), 1);
            end else begin
                run(8'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(10, 1200));
            end
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
